// File: rtl/exc_ctrl.sv
// Exception / privilege controller sitting behind the ID/EX register.
// Owns the privilege bit, captures the exception PC and faulty address,
// and sequences flush -> drain -> redirect for exceptions and iret.
//
// Input qualification: ex_valid marks a real instruction in EX. Every other
// ex_* input is a don't-care while ex_valid is 0, and while a flush/drain/
// redirect sequence is in progress (state != RUN). There is no back-pressure
// towards EX; instead stall freezes the front end for the whole sequence.
// mem_busy only pauses the drain countdown.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_2000,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ex_valid,
   input  logic        ex_exception,
   input  logic [31:0] ex_faulty_address,
   input  logic [31:0] ex_pc,
   input  logic        ex_iret,
   input  logic        ex_tlb_write,
   input  logic        mem_busy,
   output logic        privilege,
   output logic        flush,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] saved_pc,
   output logic [31:0] saved_addr,
   output logic        tlb_we,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_DRAIN    = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   localparam logic [3:0] DRAIN_CNT = 4'(DRAIN_CYCLES);
   localparam logic       KIND_EXC  = 1'b0;
   localparam logic       KIND_IRET = 1'b1;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_kind;
   logic        r_privilege;
   logic        r_flush;
   logic        r_stall;
   logic        r_redirect;
   logic [31:0] r_redirect_pc;
   logic [31:0] r_saved_pc;
   logic [31:0] r_saved_addr;
   logic        r_tlb_we;

   // A user-mode iret is illegal and is trapped exactly like an exception.
   logic w_take_exc;
   logic w_user_iret;
   logic w_kernel_iret;
   logic w_kernel_tlb;

   assign w_take_exc    = ex_valid & ex_exception;
   assign w_user_iret   = ex_valid & ex_iret & ~r_privilege;
   assign w_kernel_iret = ex_valid & ex_iret & r_privilege;
   assign w_kernel_tlb  = ex_valid & ex_tlb_write & r_privilege;

   // Sequencer: all outputs are registered here alongside the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_RUN;
         r_cnt         <= 4'd0;
         r_kind        <= KIND_EXC;
         r_privilege   <= 1'b1;
         r_flush       <= 1'b0;
         r_stall       <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'd0;
         r_saved_pc    <= 32'd0;
         r_saved_addr  <= 32'd0;
         r_tlb_we      <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_flush    <= 1'b0;
               r_redirect <= 1'b0;
               r_tlb_we   <= 1'b0;
               if (w_take_exc) begin
                  r_saved_pc   <= ex_pc;
                  r_saved_addr <= ex_faulty_address;
                  r_privilege  <= 1'b1;
                  r_flush      <= 1'b1;
                  r_stall      <= 1'b1;
                  r_cnt        <= DRAIN_CNT;
                  r_kind       <= KIND_EXC;
                  r_state      <= S_DRAIN;
               end else if (w_user_iret) begin
                  // The offending iret's own PC is reported as the fault address.
                  r_saved_pc   <= ex_pc;
                  r_saved_addr <= ex_pc;
                  r_privilege  <= 1'b1;
                  r_flush      <= 1'b1;
                  r_stall      <= 1'b1;
                  r_cnt        <= DRAIN_CNT;
                  r_kind       <= KIND_EXC;
                  r_state      <= S_DRAIN;
               end else if (w_kernel_iret) begin
                  r_flush <= 1'b1;
                  r_stall <= 1'b1;
                  r_cnt   <= DRAIN_CNT;
                  r_kind  <= KIND_IRET;
                  r_state <= S_DRAIN;
               end else if (w_kernel_tlb) begin
                  r_tlb_we <= 1'b1;
               end
            end
            S_DRAIN: begin
               r_flush <= 1'b0;
               if (!mem_busy) begin
                  if (r_cnt > 4'd1) begin
                     r_cnt <= r_cnt - 4'd1;
                  end else begin
                     r_redirect    <= 1'b1;
                     r_redirect_pc <= (r_kind == KIND_IRET) ? r_saved_pc : EXC_VECTOR;
                     r_state       <= S_REDIRECT;
                  end
               end
            end
            S_REDIRECT: begin
               r_redirect <= 1'b0;
               r_stall    <= 1'b0;
               if (r_kind == KIND_IRET) begin
                  r_privilege <= 1'b0;
               end
               r_state <= S_RUN;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign privilege   = r_privilege;
   assign flush       = r_flush;
   assign stall       = r_stall;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign saved_pc    = r_saved_pc;
   assign saved_addr  = r_saved_addr;
   assign tlb_we      = r_tlb_we;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vectors, a cycle-level
// reference model and a per-cycle compare, plus literal spot checks.
module tb_exc_ctrl;

   localparam logic [31:0] EXC_VECTOR   = 32'h0000_2000;
   localparam int          DRAIN_CYCLES = 2;

   logic        clock;
   logic        reset_n;
   logic        ex_valid;
   logic        ex_exception;
   logic [31:0] ex_faulty_address;
   logic [31:0] ex_pc;
   logic        ex_iret;
   logic        ex_tlb_write;
   logic        mem_busy;
   logic        privilege;
   logic        flush;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] saved_pc;
   logic [31:0] saved_addr;
   logic        tlb_we;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   exc_ctrl #(
      .EXC_VECTOR  (EXC_VECTOR),
      .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .ex_valid         (ex_valid),
      .ex_exception     (ex_exception),
      .ex_faulty_address(ex_faulty_address),
      .ex_pc            (ex_pc),
      .ex_iret          (ex_iret),
      .ex_tlb_write     (ex_tlb_write),
      .mem_busy         (mem_busy),
      .privilege        (privilege),
      .flush            (flush),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .saved_pc         (saved_pc),
      .saved_addr       (saved_addr),
      .tlb_we           (tlb_we),
      .dbg_state        (dbg_state)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: a pending sequence is described by how many
   // non-busy drain edges remain before the redirect is issued.
   logic        m_priv, m_flush, m_stall, m_redir, m_tlb;
   logic [31:0] m_rpc, m_spc, m_saddr;
   int          m_left;
   logic        m_iret_kind;
   logic        m_in_redirect;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_priv = 1'b1; m_flush = 1'b0; m_stall = 1'b0; m_redir = 1'b0; m_tlb = 1'b0;
         m_rpc = 32'd0; m_spc = 32'd0; m_saddr = 32'd0;
         m_left = 0; m_iret_kind = 1'b0; m_in_redirect = 1'b0;
      end else if (m_in_redirect) begin
         m_redir = 1'b0;
         m_stall = 1'b0;
         if (m_iret_kind) m_priv = 1'b0;
         m_in_redirect = 1'b0;
      end else if (m_left > 0) begin
         m_flush = 1'b0;
         if (!mem_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_redir = 1'b1;
               m_rpc = m_iret_kind ? m_spc : EXC_VECTOR;
               m_in_redirect = 1'b1;
            end
         end
      end else begin
         m_flush = 1'b0;
         m_tlb   = 1'b0;
         if (ex_valid && (ex_exception || (ex_iret && !m_priv))) begin
            m_spc   = ex_pc;
            m_saddr = ex_exception ? ex_faulty_address : ex_pc;
            m_priv  = 1'b1;
            m_flush = 1'b1;
            m_stall = 1'b1;
            m_left  = DRAIN_CYCLES;
            m_iret_kind = 1'b0;
         end else if (ex_valid && ex_iret) begin
            m_flush = 1'b1;
            m_stall = 1'b1;
            m_left  = DRAIN_CYCLES;
            m_iret_kind = 1'b1;
         end else if (ex_valid && ex_tlb_write && m_priv) begin
            m_tlb = 1'b1;
         end
      end
   end

   // Scoreboard compare on every falling edge.
   always @(negedge clock) begin
      n_checks++;
      if (privilege === m_priv && flush === m_flush && stall === m_stall &&
          redirect === m_redir && redirect_pc === m_rpc && saved_pc === m_spc &&
          saved_addr === m_saddr && tlb_we === m_tlb) begin
         n_pass++;
      end else begin
         $display("FAIL model_cmp t=%0t got priv=%b fl=%b st=%b rd=%b rpc=%h spc=%h sad=%h tlb=%b exp priv=%b fl=%b st=%b rd=%b rpc=%h spc=%h sad=%h tlb=%b",
                  $time, privilege, flush, stall, redirect, redirect_pc, saved_pc, saved_addr, tlb_we,
                  m_priv, m_flush, m_stall, m_redir, m_rpc, m_spc, m_saddr, m_tlb);
      end
   end

   // Track any redirect after a reset abort.
   logic saw_redirect;
   always @(posedge clock) if (redirect) saw_redirect = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic drive(input logic v, input logic exc, input logic [31:0] addr,
                        input logic [31:0] pc, input logic iret, input logic tlbw,
                        input logic busy);
      ex_valid = v; ex_exception = exc; ex_faulty_address = addr;
      ex_pc = pc; ex_iret = iret; ex_tlb_write = tlbw; mem_busy = busy;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      saw_redirect = 1'b0;
      reset_n = 1'b0;
      idle();
      // Reset held with inputs toggling.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cyc();
      end
      chk("rst_priv", {31'd0, privilege}, 32'd1);
      chk("rst_flush_stall_redir_tlb", {28'd0, flush, stall, redirect, tlb_we}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_spc", saved_pc, 32'd0);
      idle();
      reset_n = 1'b1;
      cyc(); cyc();
      chk("post_rst_priv", {31'd0, privilege}, 32'd1);
      chk("post_rst_state", {30'd0, dbg_state}, 32'd0);

      // Exception at 0x100.
      drive(1'b1, 1'b1, 32'hDEAD_0000, 32'h100, 1'b0, 1'b0, 1'b0);
      cyc(); idle();
      chk("exc_c1_flush", {31'd0, flush}, 32'd1);
      chk("exc_c1_stall", {31'd0, stall}, 32'd1);
      chk("exc_saved_pc", saved_pc, 32'h100);
      chk("exc_saved_addr", saved_addr, 32'hDEAD_0000);
      cyc();
      chk("exc_c2_flush_stall_redir", {29'd0, flush, stall, redirect}, 32'b010);
      cyc();
      chk("exc_c3_redir", {31'd0, redirect}, 32'd1);
      chk("exc_c3_rpc", redirect_pc, 32'h2000);
      chk("exc_c3_stall", {31'd0, stall}, 32'd1);
      cyc();
      chk("exc_c4_run", {28'd0, dbg_state, stall, redirect}, 32'd0);

      // Kernel iret back to 0x100.
      drive(1'b1, 1'b0, 32'h0, 32'h2010, 1'b1, 1'b0, 1'b0);
      cyc(); idle();
      chk("iret_c1_flush", {31'd0, flush}, 32'd1);
      cyc();
      chk("iret_c2_flush", {31'd0, flush}, 32'd0);
      cyc();
      chk("iret_c3_redir", {31'd0, redirect}, 32'd1);
      chk("iret_c3_rpc", redirect_pc, 32'h100);
      chk("iret_c3_priv", {31'd0, privilege}, 32'd1);
      cyc();
      chk("iret_c4_priv", {31'd0, privilege}, 32'd0);
      chk("iret_saved_pc_kept", saved_pc, 32'h100);

      // Exception with three busy drain cycles and a nested exception.
      drive(1'b1, 1'b1, 32'h44, 32'h400, 1'b0, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 1'b1, 32'h55, 32'h500, 1'b0, 1'b0, 1'b1);
      cyc(); cyc(); cyc();
      idle();
      cyc();
      chk("busy_c5_redir", {31'd0, redirect}, 32'd0);
      cyc();
      chk("busy_c6_redir", {31'd0, redirect}, 32'd1);
      chk("busy_saved_pc", saved_pc, 32'h400);
      chk("busy_saved_addr", saved_addr, 32'h44);
      cyc();

      // Kernel iret to drop to user mode, then a user iret traps.
      drive(1'b1, 1'b0, 32'h0, 32'h600, 1'b1, 1'b0, 1'b0);
      cyc(); idle();
      cyc(); cyc(); cyc();
      chk("user_mode", {31'd0, privilege}, 32'd0);
      // User-mode tlb_write is not privileged: no strobe.
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      cyc(); idle();
      chk("user_tlb_we", {31'd0, tlb_we}, 32'd0);
      drive(1'b1, 1'b0, 32'h0, 32'h300, 1'b1, 1'b0, 1'b0);
      cyc(); idle();
      chk("uiret_spc", saved_pc, 32'h300);
      chk("uiret_saddr", saved_addr, 32'h300);
      chk("uiret_priv", {31'd0, privilege}, 32'd1);
      cyc(); cyc();
      chk("uiret_rpc", redirect_pc, 32'h2000);
      cyc();
      chk("uiret_priv_after", {31'd0, privilege}, 32'd1);

      // Kernel TLB write.
      drive(1'b1, 1'b0, 32'h0, 32'h700, 1'b0, 1'b1, 1'b0);
      cyc(); idle();
      chk("tlb_c1", {30'd0, tlb_we, flush}, 32'b10);
      cyc();
      chk("tlb_c2", {31'd0, tlb_we}, 32'd0);
      // Excepting TLB write, combined with iret to exercise priority.
      drive(1'b1, 1'b1, 32'hBAD0, 32'h800, 1'b1, 1'b1, 1'b0);
      cyc(); idle();
      chk("exctlb_tlb", {30'd0, tlb_we, flush}, 32'b01);
      chk("exctlb_saddr", saved_addr, 32'hBAD0);
      cyc(); cyc(); cyc();

      // Reset during drain aborts the sequence.
      drive(1'b1, 1'b1, 32'h99, 32'h900, 1'b0, 1'b0, 1'b0);
      cyc(); idle();
      cyc();
      saw_redirect = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("abort_stall", {30'd0, stall, flush}, 32'd0);
      cyc();
      reset_n = 1'b1;
      cyc(); cyc(); cyc();
      chk("abort_no_redir", {31'd0, saw_redirect}, 32'd0);
      chk("abort_state", {30'd0, dbg_state}, 32'd0);
      chk("abort_spc", saved_pc, 32'd0);

      @(negedge clock);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
